ucr_seq: RTL
============

Name: ucr_seq

Overview:
Sequencer that drives a cascade of STAGES universal up/down 4-bit counter stages from the initiator side. Per stage it drives SEL and the shared CIN step clock, presents the load value, and watches the cascade's terminal-count (TC). On request it loads a start value, then issues CIN step pulses until TC reports terminal count, and signals completion. It is the command source for shift-count and loop-count counters built from those stages.

Parameters:
STAGES, 3, number of 4-bit counter stages in the cascade.
W, 4*STAGES, localparam: load and step-count width.

Ports:
CLK  in  1  system clock, also the LOAD-mode clock of the counter stages.
RESET_N  in  1  asynchronous, active-low reset.
START  in  1  request: load COUNT, then count in direction DIR; sampled only in IDLE.
DIR  in  1  1 = INC (count to all-ones), 0 = DEC (count to zero); captured with START.
COUNT  in  [0:W-1]  start value; captured with START.
ABORT  in  1  terminate the current operation, no DONE.
TC  in  1  terminal count from the most-significant stage's COUT, gated by lower-stage COUTs.
SEL  out  [0:1]  mode to all stages: 00 LOAD, 01 DEC, 10 INC, 11 HOLD.
CIN  out  1  step clock to the least-significant stage; registered, glitch-free.
LD  out  [0:W-1]  load data to the stage D inputs; holds the captured COUNT.
BUSY  out  1  high from the cycle after START acceptance until return to IDLE.
STEP  out  1  high in each cycle CIN is high.
DONE  out  1  one-cycle pulse on normal completion.
STEPS  out  [0:W-1]  number of CIN pulses issued in the current or last operation.

Behaviour:
- Reset (async assert, sync release): state IDLE, SEL=11, CIN=0, LD=0, BUSY=0, STEP=0, DONE=0, STEPS=0, dir=0. CIN drops immediately if reset arrives mid-pulse.
- All outputs are registered.
- States:
  - IDLE: SEL=11, CIN=0. On START & !ABORT: capture COUNT into LD and DIR into dir, clear STEPS, go to LOAD.
  - LOAD: one cycle, SEL=00, BUSY=1. The stages load LD on the next CLK rising edge. Go to SETTLE.
  - SETTLE: SEL = dir ? 10 : 01, CIN=0. Evaluate TC: 1 -> FIN, 0 -> PHI.
  - PHI: CIN=1, STEP=1, STEPS+1. The stages step on the CIN rising edge. Go to PLO.
  - PLO: CIN=0. Evaluate TC: 1 -> FIN, 0 -> PHI.
  - FIN: transient. The registered update sets DONE=1 for one cycle, SEL=11, BUSY=0, state=IDLE. A START arriving in the DONE cycle is accepted.
- Step rate: one step per 2 CLK cycles.
- Latency from START to DONE high: 3 + 2N cycles for N steps.
- Step count:
  - DEC: N = COUNT.
  - INC: N = 2^W-1-COUNT.
  - COUNT already terminal (0 for DEC, all-ones for INC): N=0, DONE 3 cycles after START, CIN never pulses.
- Glitch safety:
  - SEL changes only while CIN=0, immediately after a CLK rising edge (CLK high), so a stage's clock-select mux never creates a rising edge.
  - The LOAD-to-count transition switches the stage clock from CLK (high) to CIN (low), a falling edge only.
- ABORT in any busy state: next cycle state=IDLE, SEL=11, CIN=0, BUSY=0, DONE=0. STEPS keeps its value. Counter contents are left as they are.
- START and ABORT in the same IDLE cycle: ABORT wins and START is ignored.
- START while BUSY: ignored, and COUNT/DIR are not recaptured.
- TC is sampled only in SETTLE and PLO; it is ignored elsewhere, including spurious TC during LOAD.
- STEPS cannot overflow: at most 2^W-1 pulses per operation.

Decomposition:
- Shared package:
  - SEL encoding constants: SEL_LOAD=2'b00, SEL_DEC=2'b01, SEL_INC=2'b10, SEL_HOLD=2'b11. These are shared with the counter-stage users.
  - State enum: IDLE, LOAD, SETTLE, PHI, PLO.
- No sub-module needed. Single FSM plus STEPS register.
- The bench instantiates STAGES counter stages in cascade (CIN of stage k+1 = COUT of stage k) as the TC source.

Test Plan:
- DEC, COUNT=3, STAGES=1: LOAD at cycle 1, exactly 3 CIN pulses, stage Q goes 3->2->1->0, DONE at cycle 9, STEPS=3, SEL returns to 11.
- INC, COUNT=12'hFFD, STAGES=3: 2 CIN pulses, Q=12'hFFF, carry ripples across stages, DONE at cycle 7, STEPS=2.
- DEC, COUNT=0: no CIN pulse, DONE 3 cycles after START, STEPS=0.
- DEC, COUNT=20: ABORT asserted in a PHI cycle after 5 pulses -> next cycle CIN=0, SEL=11, BUSY=0, no DONE, STEPS=5, Q=15.
- RESET_N low during PHI: CIN, BUSY and SEL reset asynchronously; after release, START with COUNT=2 completes normally, STEPS=2.
- START in the DONE cycle is accepted (back-to-back). START while BUSY and START+ABORT in IDLE are both ignored. Check that SEL never changes while CIN=1 over a random run (assertion).

Source files
------------

// File: rtl/ucr_seq_pkg.sv
// ucr_seq_pkg: stage mode encoding and sequencer state type shared by the counter-stage users.
package ucr_seq_pkg;
  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_DEC  = 2'b01;
  localparam logic [1:0] SEL_INC  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, PHI, PLO} state_e;
endpackage

// File: rtl/ucr_seq_if.sv
// ucr_seq_if: command and counter-cascade signals of the sequencer; master is the sequencer side.
interface ucr_seq_if #(parameter int W = 12) ();
  logic         start;
  logic         dir;
  logic [W-1:0] count;
  logic         abort;
  logic         tc;
  logic [1:0]   sel;
  logic         cin;
  logic [W-1:0] ld;
  logic         busy;
  logic         step;
  logic         done;
  logic [W-1:0] steps;
  modport master (input start, dir, count, abort, tc, output sel, cin, ld, busy, step, done, steps);
  modport slave (output start, dir, count, abort, tc, input sel, cin, ld, busy, step, done, steps);
endinterface

// File: rtl/ucr_seq.sv
// ucr_seq: loads a cascade of 4-bit up/down stages, then pulses CIN every other cycle until TC.
module ucr_seq
  import ucr_seq_pkg::*;
#(
  parameter int STAGES = 3
) (
  input logic        clk,
  input logic        rst_n,
  ucr_seq_if.master  bus
);
  localparam int W = 4 * STAGES;
  state_e       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic         cin_q, cin_d;
  logic [W-1:0] ld_q, ld_d;
  logic         dir_q, dir_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] steps_q, steps_d;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cin_d   = 1'b0;
    ld_d    = ld_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    steps_d = steps_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      sel_d   = SEL_HOLD;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.abort) begin
          state_d = LOAD;
          sel_d   = SEL_LOAD;
          busy_d  = 1'b1;
          ld_d    = bus.count;
          dir_d   = bus.dir;
          steps_d = '0;
        end
        LOAD: begin
          state_d = SETTLE;
          sel_d   = dir_q ? SEL_INC : SEL_DEC;
        end
        // TC is only trusted once the stages sit in a counting mode with CIN low
        SETTLE, PLO: if (bus.tc) begin
          state_d = IDLE;
          sel_d   = SEL_HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = PHI;
          cin_d   = 1'b1;
          steps_d = steps_q + 1'b1;
        end
        PHI:     state_d = PLO;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_HOLD;
      cin_q   <= 1'b0;
      ld_q    <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cin_q   <= cin_d;
      ld_q    <= ld_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      steps_q <= steps_d;
    end
  end
  assign bus.sel   = sel_q;
  assign bus.cin   = cin_q;
  assign bus.step  = cin_q;
  assign bus.ld    = ld_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.steps = steps_q;
endmodule
